tone_sequencer: RTL and testbench
=================================

TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter HALF0, default 25000, half-period for tone 0 in clk_50MHz cycles (1 kHz); legal range 1..65535.
REQ-002 Parameter HALF1, default 12500, half-period for tone 1 (2 kHz); legal range 1..65535.
REQ-003 Parameter HALF2, default 6250, half-period for tone 2 (4 kHz); legal range 1..65535.
REQ-004 Parameter HALF3, default 3125, half-period for tone 3 (8 kHz); legal range 1..65535.
REQ-005 Parameter TONE_CYC, default 5000000, PLAY duration in cycles (100 ms); legal range 1..2^24-1.
REQ-006 Parameter GAP_CYC, default 500000, silent GAP duration in cycles (10 ms); legal range 1..2^24-1.
REQ-007 clk_50MHz  input  1  sole clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 btn  input  4  debounced button levels; bit i requests tone i.
REQ-010 buzz_out  output  1  square-wave buzzer drive.
REQ-011 sel  output  2  index of the tone currently loaded or playing.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 tone_done  output  1  single-cycle pulse at the end of GAP.

Function
REQ-014 The block SHALL register btn into btn_q each cycle; request edge i = btn[i] & ~btn_q[i].
REQ-015 When edges occur in the same cycle, the lowest index SHALL win; all other edges in that cycle SHALL be discarded.
REQ-016 The FSM SHALL have states IDLE, LOAD, PLAY, GAP.
REQ-017 IDLE -> LOAD on the edge following a detected request; sel SHALL take the winning index on that same edge.
REQ-018 LOAD SHALL last exactly 1 cycle, clear the half-period counter and the duration counter, and force buzz_out=0.
REQ-019 PLAY SHALL last exactly TONE_CYC cycles; buzz_out SHALL toggle each time the half counter reaches HALF[sel]-1, and the counter SHALL then wrap to 0.
REQ-020 On PLAY -> GAP, buzz_out SHALL be forced to 0 on that edge, regardless of its phase.
REQ-021 GAP SHALL last exactly GAP_CYC cycles with buzz_out=0, then go to IDLE; tone_done SHALL be 1 during the final GAP cycle only.
REQ-022 Edges detected while busy=1 SHALL be handled per REQ-027/028; sel SHALL NOT change outside the IDLE -> LOAD transition.
REQ-023 busy SHALL be a registered decode (state != IDLE).

Reset
REQ-024 While rst=1: state=IDLE, buzz_out=0, sel=0, busy=0, tone_done=0, all counters=0, pending cleared.
REQ-025 btn_q SHALL reset to 4'b1111, so that a button held across reset release generates no request until it is released and pressed again.
REQ-026 Reset asserted mid-PLAY or mid-GAP SHALL abort immediately; no tone_done pulse is produced.

Configuration
REQ-027 With TONE_QUEUE_EN defined, a one-deep pending register SHALL capture the first winning edge while busy=1; further edges SHALL be dropped while pending is full; on GAP -> IDLE with pending valid, the FSM SHALL enter LOAD on the next edge using the pending index, then clear pending.
REQ-028 Without TONE_QUEUE_EN, every edge while busy=1 SHALL be dropped, and no pending logic SHALL be synthesized.

Verification (HALF0..3=4,3,2,1; TONE_CYC=20; GAP_CYC=5)
REQ-029 btn=0001 rising edge in IDLE -> sel=0, LOAD one cycle later, buzz_out high for 4 cycles then low for 4 cycles, twice; 20 PLAY cycles; 5 GAP cycles; tone_done pulse; busy drops.
REQ-030 btn rises 0000 -> 1100 in one cycle -> sel=2, buzz_out toggles every 2 cycles; no tone 3 ever played.
REQ-031 btn[3] held high through rst deassert, then released and pressed again -> no activity until the second press, then sel=3 and buzz_out toggles every cycle.
REQ-032 Tone 1 playing, btn[0] pressed, then btn[2] pressed -> with TONE_QUEUE_EN: tone 0 plays after tone_done and tone 2 is never played; without it: returns to IDLE, nothing further.
REQ-033 rst pulsed at PLAY cycle 10 -> buzz_out=0 and busy=0 asynchronously; no tone_done; a fresh press afterwards plays a full 20 cycles.

Source files
------------

// File: rtl/tone_sequencer.sv
// Button-triggered tone sequencer: edge-detects four buttons, plays the winning tone for
// TONE_CYC cycles and follows it with a silent GAP. Define TONE_QUEUE_EN for a one-deep request queue.
module tone_sequencer #(
    parameter int unsigned HALF0    = 25000,
    parameter int unsigned HALF1    = 12500,
    parameter int unsigned HALF2    = 6250,
    parameter int unsigned HALF3    = 3125,
    parameter int unsigned TONE_CYC = 5000000,
    parameter int unsigned GAP_CYC  = 500000
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic       buzz_out,
    output logic [1:0] sel,
    output logic       busy,
    output logic       tone_done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    localparam logic [15:0] HM1_0  = 16'(HALF0 - 1);
    localparam logic [15:0] HM1_1  = 16'(HALF1 - 1);
    localparam logic [15:0] HM1_2  = 16'(HALF2 - 1);
    localparam logic [15:0] HM1_3  = 16'(HALF3 - 1);
    localparam logic [23:0] TONE_M1 = 24'(TONE_CYC - 1);
    localparam logic [23:0] GAP_M1  = 24'(GAP_CYC - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_btn_q;
    logic [3:0]  w_edge;
    logic        w_any_edge;
    logic [1:0]  w_win_idx;
    logic [1:0]  w_load_idx;
    logic        w_pend_vld;
    logic [1:0]  w_pend_idx;
    logic [15:0] r_half;
    logic [15:0] w_half_m1;
    logic [23:0] r_dur;
    logic        r_buzz;
    logic [1:0]  r_sel;
    logic        r_busy;

    // Resetting to all-ones suppresses a request from a button held across reset
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) r_btn_q <= 4'b1111;
        else     r_btn_q <= btn;
    end

    assign w_edge     = btn & ~r_btn_q;
    assign w_any_edge = |w_edge;

    always_comb begin
        w_win_idx = 2'd3;
        if      (w_edge[0]) w_win_idx = 2'd0;
        else if (w_edge[1]) w_win_idx = 2'd1;
        else if (w_edge[2]) w_win_idx = 2'd2;
    end

`ifdef TONE_QUEUE_EN
    logic       r_pend_vld;
    logic [1:0] r_pend_idx;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_pend_vld <= 1'b0;
            r_pend_idx <= 2'd0;
        end else if (r_state == S_IDLE && r_pend_vld) begin
            r_pend_vld <= 1'b0;
        end else if (r_busy && !r_pend_vld && w_any_edge) begin
            r_pend_vld <= 1'b1;
            r_pend_idx <= w_win_idx;
        end
    end

    assign w_pend_vld = r_pend_vld;
    assign w_pend_idx = r_pend_idx;
`else
    assign w_pend_vld = 1'b0;
    assign w_pend_idx = 2'd0;
`endif

    // A queued request is older than anything arriving in IDLE, so it wins
    assign w_load_idx = w_pend_vld ? w_pend_idx : w_win_idx;

    always_comb begin
        case (r_sel)
            2'd0:    w_half_m1 = HM1_0;
            2'd1:    w_half_m1 = HM1_1;
            2'd2:    w_half_m1 = HM1_2;
            default: w_half_m1 = HM1_3;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_pend_vld || w_any_edge) w_next = S_LOAD;
            S_LOAD: w_next = S_PLAY;
            S_PLAY: if (r_dur == TONE_M1) w_next = S_GAP;
            S_GAP:  if (r_dur == GAP_M1)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_half <= 16'd0;
            r_dur  <= 24'd0;
            r_buzz <= 1'b0;
            r_sel  <= 2'd0;
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_buzz <= 1'b0;
                    if (w_next == S_LOAD) r_sel <= w_load_idx;
                end
                S_LOAD: begin
                    // Tone begins in its high phase on the first PLAY cycle
                    r_half <= 16'd0;
                    r_dur  <= 24'd0;
                    r_buzz <= 1'b1;
                end
                S_PLAY: begin
                    if (r_dur == TONE_M1) begin
                        r_dur  <= 24'd0;
                        r_half <= 16'd0;
                        r_buzz <= 1'b0;
                    end else begin
                        r_dur <= r_dur + 24'd1;
                        if (r_half == w_half_m1) begin
                            r_half <= 16'd0;
                            r_buzz <= ~r_buzz;
                        end else begin
                            r_half <= r_half + 16'd1;
                        end
                    end
                end
                S_GAP: begin
                    r_buzz <= 1'b0;
                    r_dur  <= (r_dur == GAP_M1) ? 24'd0 : r_dur + 24'd1;
                end
                default: r_buzz <= 1'b0;
            endcase
        end
    end

    always_comb begin
        buzz_out  = r_buzz;
        sel       = r_sel;
        busy      = r_busy;
        tone_done = (r_state == S_GAP) && (r_dur == GAP_M1);
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: each accepted press pushes the expected tone,
// a monitor captures every tone the DUT plays and checks it against the queue head.
module tb_tone_sequencer;

    localparam int TC = 20;
    localparam int GC = 5;

    logic       clk_50MHz = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       buzz_out;
    logic [1:0] sel;
    logic       busy;
    logic       tone_done;

    typedef struct {
        logic [1:0]    sel;
        logic [TC-1:0] pat;
        logic          aborted;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   exp_done = 0;
    logic mon_busy_d;

    tone_sequencer #(
        .HALF0(4), .HALF1(3), .HALF2(2), .HALF3(1),
        .TONE_CYC(TC), .GAP_CYC(GC)
    ) dut (
        .clk_50MHz(clk_50MHz),
        .rst(rst),
        .btn(btn),
        .buzz_out(buzz_out),
        .sel(sel),
        .busy(busy),
        .tone_done(tone_done)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(negedge clk_50MHz) if (tone_done) n_done++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic int half_of(input logic [1:0] idx);
        case (idx)
            2'd0: return 4;
            2'd1: return 3;
            2'd2: return 2;
            default: return 1;
        endcase
    endfunction

    // Square wave starting high, each phase lasting half_of(idx) cycles
    function automatic logic [TC-1:0] pat_of(input logic [1:0] idx);
        logic [TC-1:0] p;
        int h;
        h = half_of(idx);
        for (int k = 0; k < TC; k++) p[k] = ((k / h) % 2) == 0;
        return p;
    endfunction

    task automatic expect_tone(input logic [1:0] idx, input logic ab);
        exp_t e;
        e.sel = idx;
        e.pat = pat_of(idx);
        e.aborted = ab;
        sb.push_back(e);
        if (!ab) exp_done++;
    endtask

    task automatic drive(input logic [3:0] b);
        @(posedge clk_50MHz);
        #1 btn = b;
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_50MHz);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, ok, 1);
        repeat (2) @(negedge clk_50MHz);
    endtask

    initial begin : monitor
        exp_t          e;
        logic [1:0]    m_sel;
        logic [TC-1:0] m_pat;
        logic [GC-1:0] m_done;
        logic          m_ab, m_gbuzz, m_ldbuzz;
        mon_busy_d = 1'b0;
        forever begin
            @(negedge clk_50MHz);
            if (busy && !mon_busy_d) begin
                m_sel = sel; m_ldbuzz = buzz_out;
                m_pat = '0; m_done = '0; m_ab = 1'b0; m_gbuzz = 1'b0;
                for (int k = 0; k < TC; k++) begin
                    @(negedge clk_50MHz);
                    if (!busy) begin m_ab = 1'b1; break; end
                    m_pat[k] = buzz_out;
                end
                if (!m_ab) begin
                    for (int g = 0; g < GC; g++) begin
                        @(negedge clk_50MHz);
                        if (!busy) begin m_ab = 1'b1; break; end
                        m_gbuzz   = m_gbuzz | buzz_out;
                        m_done[g] = tone_done;
                    end
                end
                if (!m_ab) begin
                    @(negedge clk_50MHz);
                    chk("idle_after_gap", busy, 0);
                end
                if (sb.size() == 0) begin
                    chk("unexpected_tone", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("sel", m_sel, e.sel);
                    chk("aborted", m_ab, e.aborted);
                    chk("load_buzz", m_ldbuzz, 0);
                    if (!e.aborted && !m_ab) begin
                        chk("play_pattern", m_pat, e.pat);
                        chk("gap_buzz", m_gbuzz, 0);
                        chk("done_bits", m_done, 5'b10000);
                    end
                end
            end
            mon_busy_d = busy;
        end
    end

    initial begin
        logic ok;
        rst = 1'b1;
        btn = 4'b1000;
        repeat (3) @(negedge clk_50MHz);
        chk("rst_buzz", buzz_out, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", tone_done, 0);

        // button 3 held through reset release: no request until re-pressed
        @(posedge clk_50MHz); #1 rst = 1'b0;
        repeat (10) @(negedge clk_50MHz);
        chk("held_btn_idle", busy, 0);
        drive(4'b0000);
        repeat (2) @(negedge clk_50MHz);
        expect_tone(2'd3, 1'b0);
        drive(4'b1000);
        wait_idle("wait_tone3");
        drive(4'b0000);

        expect_tone(2'd0, 1'b0);
        drive(4'b0001);
        wait_idle("wait_tone0");
        drive(4'b0000);

        // simultaneous edges: lowest index wins, the other is discarded
        expect_tone(2'd2, 1'b0);
        drive(4'b1100);
        wait_idle("wait_tone2");
        drive(4'b0000);

        // presses while busy
        expect_tone(2'd1, 1'b0);
        drive(4'b0010);
        repeat (5) @(posedge clk_50MHz);
`ifdef TONE_QUEUE_EN
        expect_tone(2'd0, 1'b0);
`endif
        #1 btn = 4'b0011;
        repeat (3) @(posedge clk_50MHz);
        #1 btn = 4'b0111;
        wait_idle("wait_busy_press");
        repeat (20) @(negedge clk_50MHz);
        drive(4'b0000);

        // reset in the middle of PLAY
        expect_tone(2'd0, 1'b1);
        drive(4'b0001);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50MHz);
            if (busy) begin ok = 1'b1; break; end
        end
        chk("abort_start", ok, 1);
        repeat (10) @(negedge clk_50MHz);
        @(posedge clk_50MHz); #2;
        chk("pre_rst_buzz", buzz_out, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_buzz", buzz_out, 0);
        chk("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk_50MHz);
        @(posedge clk_50MHz); #1 rst = 1'b0;
        wait_idle("wait_abort");
        drive(4'b0000);
        repeat (2) @(negedge clk_50MHz);
        expect_tone(2'd0, 1'b0);
        drive(4'b0001);
        wait_idle("wait_fresh");
        drive(4'b0000);

        repeat (10) @(negedge clk_50MHz);
        chk("sb_empty", sb.size(), 0);
        chk("done_pulses", n_done, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
